// File: rtl/fan_ctrl_pkg.sv
// Shared helpers for the fan controller: width math, PWM prescaler, tach slicing.
package fan_ctrl_pkg;

    localparam int SYNC_STAGES = 2;

    // ceil(log2(v)); 0 for v <= 1
    function automatic int clog2(input longint v);
        longint x;
        int     r;
        x = v - 1;
        r = 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Width needed to hold 0..n-1, never narrower than one bit
    function automatic int bits_for(input longint n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Clocks per PWM step; a too-fast PWM request degrades to one clock per step
    function automatic int presc_of(input longint clk_hz, input longint pwm_hz, input int duty_w);
        longint p;
        p = clk_hz / (pwm_hz * ((longint'(1) << duty_w) - 1));
        return (p < 1) ? 1 : int'(p);
    endfunction

    // LSB of channel ch inside the flattened count bus
    function automatic int tach_lo(input int ch, input int cnt_w);
        return ch * cnt_w;
    endfunction

endpackage

// File: rtl/fan_tach_ch.sv
// One tach channel: async input synchroniser, rising-edge detect, saturating counter.
module fan_tach_ch
    import fan_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tach,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   rise;

    assign rise = sync[SYNC_STAGES-1] & ~prev;

    // Bring the raw tach pin into the clock domain and keep the last level for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], tach};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    // Count edges; at window end restart, keeping an edge that lands on the boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= rise ? CNT_W'(1) : '0;
        end else if (rise && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fan_ctrl_nch.sv
// Fan controller: shadowed-duty PWM plus N gated tach counters with sticky stall flags.
module fan_ctrl_nch
    import fan_ctrl_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int PWM_HZ      = 25_000,
    parameter int DUTY_W      = 8,
    parameter int N_FAN       = 6,
    parameter int CNT_W       = 16,
    parameter int GATE_CYC    = 100_000_000,
    parameter int STALL_MIN   = 2,
    parameter int GRACE_WIN   = 2,
    parameter int FAILSAFE_EN = 1
) (
    input  logic                   i_sys_aclk,
    input  logic                   i_sys_aresetn,
    input  logic [DUTY_W-1:0]      i_duty,
    input  logic                   i_duty_vld,
    input  logic [N_FAN-1:0]       i_fan_speed,
    input  logic                   i_stall_clr,
    output logic                   o_fan_pwm,
    output logic [N_FAN*CNT_W-1:0] o_tach_cnt,
    output logic                   o_tach_vld,
    output logic [N_FAN-1:0]       o_stall
);

    localparam int PRESC    = presc_of(CLK_HZ, PWM_HZ, DUTY_W);
    localparam int PW       = bits_for(PRESC);
    localparam int STEP_MAX = (1 << DUTY_W) - 2;
    localparam int GW       = bits_for(GATE_CYC);
    localparam int GRW      = bits_for(GRACE_WIN + 1);

    logic [PW-1:0]                presc_cnt;
    logic                         presc_tick;
    logic [DUTY_W-1:0]            step;
    logic                         wrap;
    logic [DUTY_W-1:0]            duty_pend;
    logic [DUTY_W-1:0]            duty_act;
    logic [GW-1:0]                gate_cnt;
    logic                         gate_tc;
    logic [GRW-1:0]               grace;
    logic                         duty_rise;
    logic [N_FAN-1:0]             stall_set;
    logic [N_FAN-1:0][CNT_W-1:0]  cnt_v;

    assign presc_tick = (presc_cnt == PW'(PRESC - 1));
    assign wrap       = presc_tick && (step == DUTY_W'(STEP_MAX));
    assign gate_tc    = (gate_cnt == '0);
    assign duty_rise  = wrap && (duty_act == '0) && (duty_pend != '0);

    genvar g;
    generate
        for (g = 0; g < N_FAN; g++) begin : g_ch
            fan_tach_ch #(.CNT_W(CNT_W)) u_ch (
                .clk   (i_sys_aclk),
                .rst_n (i_sys_aresetn),
                .tach  (i_fan_speed[g]),
                .clr   (gate_tc),
                .cnt   (cnt_v[g])
            );
        end
    endgenerate

    // Prescaler and PWM step counter
    always_ff @(posedge i_sys_aclk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            presc_cnt <= '0;
            step      <= '0;
        end else if (presc_tick) begin
            presc_cnt <= '0;
            step      <= wrap ? '0 : step + DUTY_W'(1);
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
        end
    end

    // Duty shadow: host writes land in pending, active only changes at period wrap
    always_ff @(posedge i_sys_aclk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            duty_pend <= '1;
            duty_act  <= '1;
        end else begin
            if (i_duty_vld) duty_pend <= i_duty;
            if (wrap)       duty_act  <= duty_pend;
        end
    end

    // Measurement gate down-counter
    always_ff @(posedge i_sys_aclk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) gate_cnt <= GW'(GATE_CYC - 1);
        else                gate_cnt <= gate_tc ? GW'(GATE_CYC - 1) : gate_cnt - GW'(1);
    end

    // Grace windows: a fan that is just spinning up is not judged yet
    always_ff @(posedge i_sys_aclk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn)                  grace <= GRW'(GRACE_WIN);
        else if (duty_rise)                  grace <= GRW'(GRACE_WIN);
        else if (gate_tc && (grace != '0))   grace <= grace - GRW'(1);
    end

    // Stall condition per channel at window end
    always_comb begin
        stall_set = '0;
        for (int i = 0; i < N_FAN; i++)
            stall_set[i] = gate_tc && (cnt_v[i] < CNT_W'(STALL_MIN)) &&
                           (duty_act != '0) && (grace == '0);
    end

    // Publish counts, sticky stall flags (a new stall beats a clear), PWM output
    always_ff @(posedge i_sys_aclk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            o_tach_cnt <= '0;
            o_tach_vld <= 1'b0;
            o_stall    <= '0;
            o_fan_pwm  <= 1'b1;
        end else begin
            o_tach_vld <= gate_tc;
            if (gate_tc)
                for (int i = 0; i < N_FAN; i++)
                    o_tach_cnt[tach_lo(i, CNT_W) +: CNT_W] <= cnt_v[i];
            o_stall   <= (o_stall & ~{N_FAN{i_stall_clr}}) | stall_set;
            o_fan_pwm <= (step < duty_act) || ((FAILSAFE_EN != 0) && (|o_stall));
        end
    end

endmodule

// File: tb/tb_fan_ctrl_nch.sv
// Randomized bench for fan_ctrl_nch: scripted tach waveforms per window, duty sweeps.
module tb_fan_ctrl_nch;

    localparam int CLK_HZ    = 1_000_000;
    localparam int PWM_HZ    = 1000;
    localparam int DUTY_W    = 4;
    localparam int N_FAN     = 2;
    // narrow count so saturation is reachable inside a 1000-clock window
    localparam int CNT_W     = 8;
    localparam int GATE_CYC  = 1000;
    localparam int STALL_MIN = 2;
    localparam int GRACE_WIN = 2;
    localparam int STEP_CLK  = 66;          // 1e6 / (1000 * 15)
    localparam int PERIOD    = 15 * STEP_CLK;
    localparam int SAT       = (1 << CNT_W) - 1;
    localparam int NW        = 32;
    localparam int SW        = 21;          // window where ch1 goes silent

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [DUTY_W-1:0]      duty;
    logic                   duty_vld;
    logic [N_FAN-1:0]       tach;
    logic                   stall_clr;
    logic                   pwm;
    logic [N_FAN*CNT_W-1:0] tach_cnt;
    logic                   tach_vld;
    logic [N_FAN-1:0]       stall;

    fan_ctrl_nch #(
        .CLK_HZ(CLK_HZ), .PWM_HZ(PWM_HZ), .DUTY_W(DUTY_W), .N_FAN(N_FAN),
        .CNT_W(CNT_W), .GATE_CYC(GATE_CYC), .STALL_MIN(STALL_MIN),
        .GRACE_WIN(GRACE_WIN), .FAILSAFE_EN(1)
    ) dut (
        .i_sys_aclk    (clk),
        .i_sys_aresetn (rst_n),
        .i_duty        (duty),
        .i_duty_vld    (duty_vld),
        .i_fan_speed   (tach),
        .i_stall_clr   (stall_clr),
        .o_fan_pwm     (pwm),
        .o_tach_cnt    (tach_cnt),
        .o_tach_vld    (tach_vld),
        .o_stall       (stall)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    int plan0 [NW];
    int plan1 [NW];
    bit bnd   [NW];
    int exp0  [NW];
    int exp1  [NW];
    int vcount = 0;
    logic [N_FAN-1:0] stall_exp = '0;
    bit drv_on = 1'b1;
    bit chk_en = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // clocks since reset release
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    // n evenly spaced pulses inside offsets 10..950 of a window
    function automatic logic lvl(input int n, input int off);
        int p;
        if (n <= 0) return 1'b0;
        p = 940 / n;
        if (p < 2) p = 2;
        if (off < 10 || off >= 10 + n * p) return 1'b0;
        return ((off - 10) % p) < (p / 2);
    endfunction

    task automatic set_duty(input int d);
        @(posedge clk); #1;
        duty = DUTY_W'(d);
        duty_vld = 1'b1;
        @(posedge clk); #1;
        duty_vld = 1'b0;
    endtask

    task automatic meas(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm) hi++;
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(posedge clk);
    endtask

    // tach waveform driver, scripted per measurement window
    initial begin : drv
        int w, off;
        tach = '0;
        @(posedge rst_n);
        forever begin
            @(posedge clk); #1;
            if (!drv_on) begin
                tach = '0;
            end else begin
                w   = cyc / GATE_CYC;
                off = cyc % GATE_CYC;
                if (w >= NW) w = NW - 1;
                tach[0] = lvl(plan0[w], off);
                tach[1] = lvl(plan1[w], off);
                // rising edge that reaches the counter exactly on the window boundary
                if (bnd[w] && off >= 997) tach[0] = 1'b1;
            end
        end
    end

    // window checker: every o_tach_vld is compared with the planned counts
    initial begin : mon
        int wi;
        forever begin
            @(negedge clk);
            if (chk_en && rst_n && tach_vld) begin
                wi = (vcount < NW) ? vcount : NW - 1;
                chk($sformatf("tach0_w%0d", vcount), tach_cnt[0 +: CNT_W], exp0[wi]);
                chk($sformatf("tach1_w%0d", vcount), tach_cnt[CNT_W +: CNT_W], exp1[wi]);
                if (vcount >= GRACE_WIN) begin
                    if (exp0[wi] < STALL_MIN) stall_exp[0] = 1'b1;
                    if (exp1[wi] < STALL_MIN) stall_exp[1] = 1'b1;
                end
                chk($sformatf("stall_w%0d", vcount), stall, stall_exp);
                vcount++;
            end
        end
    end

    initial begin : main
        int n, hi, d, run, bad, n9, e;
        bit got, seen, prev;

        for (int w = 0; w < NW; w++) begin
            plan0[w] = $urandom_range(150, 2);
            plan1[w] = $urandom_range(400, 2);
            bnd[w]   = 1'b0;
        end
        plan0[0] = 0;   plan1[0] = 0;
        plan0[2] = 37;  plan1[2] = 300;
        bnd[4]   = 1'b1;
        plan1[SW] = 0;
        for (int w = 0; w < NW; w++) begin
            e = plan0[w] + ((w > 0 && bnd[w-1]) ? 1 : 0);
            exp0[w] = (e > SAT) ? SAT : e;
            exp1[w] = (plan1[w] > SAT) ? SAT : plan1[w];
        end

        rst_n = 1'b0; duty = '0; duty_vld = 1'b0; stall_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", pwm, 1);
        chk("rst_cnt", tach_cnt, 0);
        chk("rst_vld", tach_vld, 0);
        chk("rst_stall", stall, 0);
        rst_n = 1'b1;

        // idle first window: PWM constantly high, first publish after GATE_CYC clocks
        n = 0; hi = 0; got = 1'b0;
        while (n < 1200 && !got) begin
            @(negedge clk);
            n++;
            if (pwm) hi++;
            if (tach_vld) got = 1'b1;
        end
        chk("first_vld_clk", n, GATE_CYC);
        chk("idle_pwm_hi", hi, GATE_CYC);

        set_duty(5);  repeat (1000) @(negedge clk); meas(PERIOD, hi); chk("duty5_hi", hi, 5 * STEP_CLK);
        set_duty(0);  repeat (1000) @(negedge clk); meas(PERIOD, hi); chk("duty0_hi", hi, 0);
        set_duty(15); repeat (1000) @(negedge clk); meas(PERIOD, hi); chk("duty15_hi", hi, PERIOD);

        // two strobes in one period: only the last one may ever appear on the pin
        set_duty(5); repeat (1000) @(negedge clk);
        n = 0; prev = pwm;
        while (n < 1000 && !(prev && !pwm)) begin
            prev = pwm;
            @(negedge clk);
            n++;
        end
        chk("runt_sync_found", (n < 1000), 1);
        set_duty(3);
        set_duty(9);
        bad = 0; n9 = 0; run = 0; seen = 1'b0; prev = pwm;
        repeat (2100) begin
            @(negedge clk);
            if (pwm && !prev) begin seen = 1'b1; run = 0; end
            if (pwm) run++;
            if (!pwm && prev && seen) begin
                if (run == 9 * STEP_CLK) n9++;
                else if (run != 5 * STEP_CLK) bad++;
            end
            prev = pwm;
        end
        chk("runt_pulses", bad, 0);
        chk("duty9_seen", (n9 > 0), 1);
        meas(PERIOD, hi); chk("duty9_hi", hi, 9 * STEP_CLK);

        repeat (3) begin
            d = $urandom_range(14, 1);
            set_duty(d);
            repeat (1000) @(negedge clk);
            meas(PERIOD, hi);
            chk($sformatf("duty%0d_hi", d), hi, d * STEP_CLK);
        end

        // stall on ch1, fail-safe forcing, then clear
        wait_cyc(19000);
        set_duty(8);
        wait_cyc((SW + 1) * GATE_CYC + 10);
        chk("stall_set", stall, 2'b10);
        meas(PERIOD, hi); chk("failsafe_hi", hi, PERIOD);
        wait_cyc((SW + 2) * GATE_CYC + 100);
        @(posedge clk); #1 stall_clr = 1'b1;
        @(posedge clk); #1 stall_clr = 1'b0;
        stall_exp = '0;
        @(negedge clk);
        chk("stall_clr", stall, 0);
        meas(PERIOD, hi); chk("duty8_after_clr", hi, 8 * STEP_CLK);
        wait_cyc(24200);
        chk("vld_count", vcount, 24);

        // asynchronous reset in the middle of a window
        drv_on = 1'b0; chk_en = 1'b0;
        n = 0;
        while (n < 1000 && pwm) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pwm", pwm, 1);
        chk("mid_rst_cnt", tach_cnt, 0);
        chk("mid_rst_vld", tach_vld, 0);
        chk("mid_rst_stall", stall, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0; got = 1'b0;
        while (n < 1200 && !got) begin
            @(negedge clk);
            n++;
            if (tach_vld) got = 1'b1;
        end
        chk("rerst_vld_clk", n, GATE_CYC);
        chk("rerst_cnt", tach_cnt, 0);
        chk("rerst_stall", stall, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
